// File: rtl/ddr_rd_sch_nch.sv
// ---------------------------------------------------------------------------
// ddr_rd_sch_nch
//   N-channel DDR read-burst scheduler. Arbitrates CH_NUM client read-burst
//   requests (round-robin, with a per-channel urgent override) onto the one
//   read-burst command port of the DDR controller. Returned data, valid and
//   finish are routed to the granted channel only. The number of returned
//   beats is checked against the burst length, and a burst that never
//   finishes is cut off after TIMEOUT_CYC cycles. Both faults raise sticky
//   flags.
//
// Ports
//   ddr_clk, ddr_rst          clock, synchronous active-high reset
//   ddr_burst_idle            controller ready to take a new command
//   ch_rd_burst_req/_urgent   per-channel request level and urgent qualifier
//   ch_rd_burst_len/_addr     flattened per-channel length/address
//                             (channel i at [i*W +: W])
//   ch_rd_burst_gnt           one-hot grant pulse, high in the cycle the
//                             command issues
//   ch_rd_burst_data_valid    one-hot routed data valid
//   ch_rd_burst_data          read data, shared by all channels
//   ch_rd_burst_finish        one-hot routed (or synthetic) finish pulse
//   rd_burst_req/_len/_addr   command to the controller (len/addr registered)
//   rd_burst_data_valid/_data/_finish  data returned by the controller
//   err_clr                   clears the sticky error flags
//   sch_busy                  scheduler not idle
//   err_len, err_timeout      sticky beat-count / timeout errors
//   err_ch                    channel of the most recent error
// ---------------------------------------------------------------------------
module ddr_rd_sch_nch #(
  parameter int CH_NUM      = 8,
  parameter int IDX_WD      = 3,
  parameter int DDR_ADDR_WD = 16,
  parameter int DDR_DATA_WD = 512,
  parameter int LEN_WD      = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          ddr_clk,
  input  logic                          ddr_rst,
  input  logic                          ddr_burst_idle,
  input  logic [CH_NUM-1:0]             ch_rd_burst_req,
  input  logic [CH_NUM-1:0]             ch_rd_burst_urgent,
  input  logic [CH_NUM*LEN_WD-1:0]      ch_rd_burst_len,
  input  logic [CH_NUM*DDR_ADDR_WD-1:0] ch_rd_burst_addr,
  output logic [CH_NUM-1:0]             ch_rd_burst_gnt,
  output logic [CH_NUM-1:0]             ch_rd_burst_data_valid,
  output logic [DDR_DATA_WD-1:0]        ch_rd_burst_data,
  output logic [CH_NUM-1:0]             ch_rd_burst_finish,
  output logic                          rd_burst_req,
  output logic [LEN_WD-1:0]             rd_burst_len,
  output logic [DDR_ADDR_WD-1:0]        rd_burst_addr,
  input  logic                          rd_burst_data_valid,
  input  logic [DDR_DATA_WD-1:0]        rd_burst_data,
  input  logic                          rd_burst_finish,
  input  logic                          err_clr,
  output logic                          sch_busy,
  output logic                          err_len,
  output logic                          err_timeout,
  output logic [IDX_WD-1:0]             err_ch
);

  localparam int TMR_WD = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_WD-1:0] TMR_LAST = TMR_WD'(TIMEOUT_CYC - 1);
  localparam logic [IDX_WD:0]   CH_NUM_W = (IDX_WD + 1)'(CH_NUM);
  localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(CH_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DATA,
    ST_GAP
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_WD-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_WD-1:0]       lock_idx_q, lock_idx_d;
  logic [LEN_WD-1:0]       len_q, len_d;
  logic [DDR_ADDR_WD-1:0]  addr_q, addr_d;
  logic [LEN_WD-1:0]       beat_cnt_q, beat_cnt_d;
  logic [TMR_WD-1:0]       timer_q, timer_d;
  logic                    err_len_q, err_len_d;
  logic                    err_timeout_q, err_timeout_d;
  logic [IDX_WD-1:0]       err_ch_q, err_ch_d;

  // Arbitration
  logic [CH_NUM-1:0]       cand;
  logic [IDX_WD:0]         scan_pos;
  logic                    win_vld;
  logic [IDX_WD-1:0]       win_idx;

  // Burst tracking
  logic                    data_en;
  logic                    timeout_hit;
  logic                    burst_end;
  logic                    set_len;
  logic                    set_to;
  logic [LEN_WD:0]         beat_sum;
  logic [CH_NUM-1:0]       lock_oh;

  // Urgent requesters, when present, shadow all others. The search starts at
  // rr_ptr and wraps at CH_NUM, which need not be a power of two.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    cand     = ((ch_rd_burst_req & ch_rd_burst_urgent) != '0)
             ? (ch_rd_burst_req & ch_rd_burst_urgent) : ch_rd_burst_req;
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_pos = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      scan_pos = {1'b0, rr_ptr_q} + (IDX_WD + 1)'(k);
      if (scan_pos >= CH_NUM_W) scan_pos = scan_pos - CH_NUM_W;
      if (!win_vld && cand[scan_pos[IDX_WD-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_pos[IDX_WD-1:0];
      end
    end
  end

  assign data_en     = (state_q == ST_DATA);
  // The finish cycle may carry the last beat, so it counts towards the total.
  // A saturated counter plus one valid lands on 2**LEN_WD, which never
  // matches a real length and therefore flags the overrun.
  assign beat_sum    = {1'b0, beat_cnt_q} + {{LEN_WD{1'b0}}, rd_burst_data_valid};
  assign timeout_hit = data_en && !rd_burst_finish && (timer_q == TMR_LAST);
  assign burst_end   = data_en && (rd_burst_finish || timeout_hit);
  assign lock_oh     = CH_NUM'(1) << lock_idx_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lock_idx_d    = lock_idx_q;
    len_d         = len_q;
    addr_d        = addr_q;
    beat_cnt_d    = beat_cnt_q;
    timer_d       = timer_q;
    set_len       = 1'b0;
    set_to        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ddr_burst_idle && win_vld) begin
          lock_idx_d = win_idx;
          len_d      = ch_rd_burst_len[win_idx*LEN_WD +: LEN_WD];
          addr_d     = ch_rd_burst_addr[win_idx*DDR_ADDR_WD +: DDR_ADDR_WD];
          rr_ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_WD'(1);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        beat_cnt_d = '0;
        timer_d    = '0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        timer_d = timer_q + TMR_WD'(1);
        if (rd_burst_data_valid && (beat_cnt_q != '1)) begin
          beat_cnt_d = beat_cnt_q + LEN_WD'(1);
        end
        if (rd_burst_finish) begin
          set_len = (beat_sum != {1'b0, len_q});
          state_d = ST_GAP;
        end else if (timeout_hit) begin
          set_to  = 1'b1;
          state_d = ST_GAP;
        end
      end
      // One dead cycle so the controller can drop ddr_burst_idle before the
      // next arbitration looks at it.
      ST_GAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new error in the same cycle as err_clr must not be lost.
    err_len_d     = set_len ? 1'b1 : (err_clr ? 1'b0 : err_len_q);
    err_timeout_d = set_to  ? 1'b1 : (err_clr ? 1'b0 : err_timeout_q);
    err_ch_d      = (set_len || set_to) ? lock_idx_q : err_ch_q;
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      lock_idx_q    <= '0;
      len_q         <= '0;
      addr_q        <= '0;
      beat_cnt_q    <= '0;
      timer_q       <= '0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ch_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state, so every register
      // samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_idx_q    <= lock_idx_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      beat_cnt_q    <= beat_cnt_d;
      timer_q       <= timer_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_ch_q      <= err_ch_d;
    end
  end

  // Channel-side outputs are gated to DATA, so stray controller activity
  // outside a burst (including after a reset) never reaches a client.
  assign rd_burst_req           = (state_q == ST_ISSUE);
  assign rd_burst_len           = len_q;
  assign rd_burst_addr          = addr_q;
  assign ch_rd_burst_gnt        = {CH_NUM{rd_burst_req}} & lock_oh;
  assign ch_rd_burst_data_valid = {CH_NUM{data_en && rd_burst_data_valid}} & lock_oh;
  assign ch_rd_burst_finish     = {CH_NUM{burst_end}} & lock_oh;
  assign ch_rd_burst_data       = data_en ? rd_burst_data : '0;
  assign sch_busy               = (state_q != ST_IDLE);
  assign err_len                = err_len_q;
  assign err_timeout            = err_timeout_q;
  assign err_ch                 = err_ch_q;

endmodule

// File: tb/tb_ddr_rd_sch_nch.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_sch_nch
//   Directed bench for ddr_rd_sch_nch (8 channels, TIMEOUT_CYC = 16).
//   Inputs change 1 time unit after a rising edge; outputs are compared
//   1 time unit after that, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_ddr_rd_sch_nch;

  localparam int CH = 8;
  localparam int IW = 3;
  localparam int AW = 16;
  localparam int DW = 512;
  localparam int LW = 10;
  localparam int TO = 16;

  logic               clk;
  logic               rst;
  logic               idle;
  logic [CH-1:0]      ch_req;
  logic [CH-1:0]      ch_urg;
  logic [CH*LW-1:0]   ch_len;
  logic [CH*AW-1:0]   ch_addr;
  logic [CH-1:0]      gnt;
  logic [CH-1:0]      dv;
  logic [DW-1:0]      ch_data;
  logic [CH-1:0]      fin;
  logic               cmd_req;
  logic [LW-1:0]      cmd_len;
  logic [AW-1:0]      cmd_addr;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic               rd_fin;
  logic               err_clr;
  logic               busy;
  logic               e_len;
  logic               e_to;
  logic [IW-1:0]      e_ch;

  logic [LW-1:0]      lens  [CH];
  logic [AW-1:0]      addrs [CH];

  int total = 0;
  int bad   = 0;

  ddr_rd_sch_nch #(
    .CH_NUM(CH), .IDX_WD(IW), .DDR_ADDR_WD(AW), .DDR_DATA_WD(DW),
    .LEN_WD(LW), .TIMEOUT_CYC(TO)
  ) dut (
    .ddr_clk(clk), .ddr_rst(rst), .ddr_burst_idle(idle),
    .ch_rd_burst_req(ch_req), .ch_rd_burst_urgent(ch_urg),
    .ch_rd_burst_len(ch_len), .ch_rd_burst_addr(ch_addr),
    .ch_rd_burst_gnt(gnt), .ch_rd_burst_data_valid(dv),
    .ch_rd_burst_data(ch_data), .ch_rd_burst_finish(fin),
    .rd_burst_req(cmd_req), .rd_burst_len(cmd_len), .rd_burst_addr(cmd_addr),
    .rd_burst_data_valid(rd_valid), .rd_burst_data(rd_data),
    .rd_burst_finish(rd_fin), .err_clr(err_clr), .sch_busy(busy),
    .err_len(e_len), .err_timeout(e_to), .err_ch(e_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ch_len  = '0;
    ch_addr = '0;
    for (int i = 0; i < CH; i++) begin
      ch_len[i*LW +: LW]  = lens[i];
      ch_addr[i*AW +: AW] = addrs[i];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Runs one complete burst for channel ch starting from an IDLE cycle in
  // which the caller has already raised the request(s).
  task automatic do_burst(input int ch, input int nbeats, input bit fin_valid,
                          input bit clr_fin, input bit drop);
    logic [IW-1:0] ci;
    logic [CH-1:0] oh;
    ci = IW'(ch);
    oh = CH'(1) << ci;
    settle();
    total++;
    if (cmd_req !== 1'b0) begin
      bad++; $display("FAIL idle_no_cmd ch%0d: got %b want 0", ch, cmd_req);
    end
    step();  // ISSUE
    total++;
    if ({gnt, cmd_req} !== {oh, 1'b1}) begin
      bad++; $display("FAIL issue_gnt ch%0d: got gnt=%b req=%b want gnt=%b req=1",
                      ch, gnt, cmd_req, oh);
    end
    total++;
    if ({cmd_len, cmd_addr} !== {lens[ci], addrs[ci]}) begin
      bad++; $display("FAIL issue_cmd ch%0d: got len=%0d addr=%h want len=%0d addr=%h",
                      ch, cmd_len, cmd_addr, lens[ci], addrs[ci]);
    end
    if (drop) ch_req[ci] = 1'b0;
    step();  // first DATA cycle
    for (int b = 0; b < nbeats; b++) begin
      rd_valid = 1'b1;
      rd_data  = {16{32'hA5A5_0000 + 32'(b)}};
      settle();
      total++;
      if (dv !== oh || ch_data !== rd_data) begin
        bad++; $display("FAIL beat ch%0d b%0d: got dv=%b data[31:0]=%h want dv=%b data[31:0]=%h",
                        ch, b, dv, ch_data[31:0], oh, rd_data[31:0]);
      end
      step();
    end
    rd_valid = fin_valid;
    rd_fin   = 1'b1;
    err_clr  = clr_fin;
    settle();
    total++;
    if (fin !== oh || dv !== (fin_valid ? oh : '0)) begin
      bad++; $display("FAIL finish ch%0d: got fin=%b dv=%b want fin=%b", ch, fin, dv, oh);
    end
    step();  // GAP: controller activity here must be dropped
    err_clr  = 1'b0;
    rd_valid = 1'b1;
    rd_fin   = 1'b1;
    settle();
    total++;
    if ({busy, dv, fin} !== {1'b1, {CH{1'b0}}, {CH{1'b0}}}) begin
      bad++; $display("FAIL gap ch%0d: got busy=%b dv=%b fin=%b want busy=1 dv=0 fin=0",
                      ch, busy, dv, fin);
    end
    step();  // IDLE
    rd_valid = 1'b0;
    rd_fin   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    settle();
    total++;
    if ({gnt, dv, fin, cmd_req, cmd_len, cmd_addr, busy, e_len, e_to, e_ch} !== '0) begin
      bad++; $display("FAIL reset_outputs: got gnt=%b dv=%b fin=%b req=%b len=%0d addr=%h busy=%b el=%b et=%b ec=%0d want all 0",
                      gnt, dv, fin, cmd_req, cmd_len, cmd_addr, busy, e_len, e_to, e_ch);
    end
    total++;
    if (ch_data !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", ch_data[31:0]);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    lens[2]  = 10'd4;
    addrs[2] = 16'h0123;
    ch_req   = 8'b0000_0100;
    do_burst(2, 4, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if ({e_len, e_to} !== 2'b00) begin
      bad++; $display("FAIL single_err: got len=%b to=%b want 00", e_len, e_to);
    end
  endtask

  task automatic test_idle_gate();
    idle      = 1'b0;
    ch_req[5] = 1'b1;
    step();
    settle();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_gate_hold: got busy=%b want 0", busy);
    end
    ch_req[5] = 1'b0;
    idle      = 1'b1;
    step();
    settle();
    total++;
    if ({busy, gnt} !== '0) begin
      bad++; $display("FAIL withdrawn_req: got busy=%b gnt=%b want 0", busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 3, 5, 0, 3, 5};
    apply_reset();
    lens[0] = 10'd2; addrs[0] = 16'h1000;
    lens[3] = 10'd2; addrs[3] = 16'h3000;
    lens[5] = 10'd2; addrs[5] = 16'h5000;
    ch_req  = 8'b0010_1001;
    for (int r = 0; r < 6; r++) do_burst(order[r], 2, 1'b0, 1'b0, 1'b0);
    ch_req = '0;
    settle();
    total++;
    if (e_len !== 1'b0) begin
      bad++; $display("FAIL rr_err: got err_len=%b want 0", e_len);
    end
  endtask

  task automatic test_urgent();
    apply_reset();
    lens[0] = 10'd1; addrs[0] = 16'h0A00;
    ch_req  = 8'b0000_0001;
    do_burst(0, 1, 1'b0, 1'b0, 1'b1);   // rr_ptr now 1
    lens[1] = 10'd3; addrs[1] = 16'h0B01;
    lens[6] = 10'd2; addrs[6] = 16'h0C06;
    ch_req  = 8'b0100_0010;
    ch_urg  = 8'b0100_0000;
    do_burst(6, 2, 1'b0, 1'b0, 1'b1);   // urgent wins, rr_ptr -> 7
    do_burst(1, 3, 1'b0, 1'b0, 1'b1);   // wraps 7 -> 0 -> 1
    ch_urg = '0;
  endtask

  task automatic test_len_error();
    lens[4]  = 10'd8;
    addrs[4] = 16'h4444;
    ch_req[4] = 1'b1;
    // err_clr held in the finishing cycle: the new error must still land.
    do_burst(4, 7, 1'b0, 1'b1, 1'b1);
    settle();
    total++;
    if ({e_len, e_to} !== 2'b10) begin
      bad++; $display("FAIL len_err_set: got len=%b to=%b want 10", e_len, e_to);
    end
    total++;
    if (e_ch !== 3'd4) begin
      bad++; $display("FAIL len_err_ch: got %0d want 4", e_ch);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    settle();
    total++;
    if (e_len !== 1'b0) begin
      bad++; $display("FAIL len_err_clr: got %b want 0", e_len);
    end
  endtask

  task automatic test_len_edges();
    lens[2]   = 10'd0;
    ch_req[2] = 1'b1;
    do_burst(2, 0, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if (e_len !== 1'b0) begin
      bad++; $display("FAIL len_zero: got err_len=%b want 0", e_len);
    end
    // Third beat arrives together with finish.
    lens[6]   = 10'd3;
    ch_req[6] = 1'b1;
    do_burst(6, 2, 1'b1, 1'b0, 1'b1);
    settle();
    total++;
    if (e_len !== 1'b0) begin
      bad++; $display("FAIL len_last_with_fin: got err_len=%b want 0", e_len);
    end
  endtask

  task automatic test_timeout();
    lens[7]   = 10'd4;
    addrs[7]  = 16'h7777;
    ch_req[7] = 1'b1;
    settle();
    step();  // ISSUE
    total++;
    if (gnt !== 8'b1000_0000) begin
      bad++; $display("FAIL to_gnt: got %b want 10000000", gnt);
    end
    ch_req[7] = 1'b0;
    step();  // first DATA cycle
    for (int d = 0; d < TO; d++) begin
      settle();
      total++;
      if (fin !== ((d == TO - 1) ? 8'b1000_0000 : 8'b0)) begin
        bad++; $display("FAIL to_fin d%0d: got %b", d, fin);
      end
      step();
    end
    rd_fin = 1'b1;   // late controller finish, must be dropped
    settle();
    total++;
    if (fin !== '0) begin
      bad++; $display("FAIL to_late_fin: got %b want 0", fin);
    end
    total++;
    if ({e_to, e_len, e_ch} !== {1'b1, 1'b0, 3'd7}) begin
      bad++; $display("FAIL to_err: got to=%b len=%b ch=%0d want to=1 len=0 ch=7",
                      e_to, e_len, e_ch);
    end
    step();
    rd_fin    = 1'b0;
    lens[1]   = 10'd1;
    addrs[1]  = 16'h0111;
    ch_req[1] = 1'b1;
    do_burst(1, 1, 1'b0, 1'b0, 1'b1);
    settle();
    total++;
    if ({e_to, e_len} !== 2'b10) begin
      bad++; $display("FAIL to_after: got to=%b len=%b want 10", e_to, e_len);
    end
  endtask

  task automatic test_reset_mid_data();
    lens[3]   = 10'd8;
    addrs[3]  = 16'h3333;
    ch_req[3] = 1'b1;
    settle();
    step();          // ISSUE, rr_ptr now 4
    ch_req[3] = 1'b0;
    step();          // DATA
    rd_valid = 1'b1;
    step();          // beat 1 taken
    step();          // beat 2 taken
    rst = 1'b1;      // beat 3 present together with reset
    settle();
    total++;
    if (dv !== 8'b0000_1000) begin
      bad++; $display("FAIL rst_beat3: got dv=%b want 00001000", dv);
    end
    step();
    rst    = 1'b0;
    rd_fin = 1'b1;   // controller still active after the reset
    settle();
    total++;
    if ({gnt, dv, fin, cmd_req, cmd_len, cmd_addr, busy, e_len, e_to, e_ch} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: got gnt=%b dv=%b fin=%b req=%b len=%0d addr=%h busy=%b el=%b et=%b ec=%0d want all 0",
                      gnt, dv, fin, cmd_req, cmd_len, cmd_addr, busy, e_len, e_to, e_ch);
    end
    total++;
    if (ch_data !== '0) begin
      bad++; $display("FAIL rst_mid_data: got %h want 0", ch_data[31:0]);
    end
    step();
    rd_valid = 1'b0;
    rd_fin   = 1'b0;
    // rr_ptr back at 0: ch0 beats ch5 (from 4 it would be ch5).
    lens[0] = 10'd1; lens[5] = 10'd1;
    ch_req  = 8'b0010_0001;
    do_burst(0, 1, 1'b0, 1'b0, 1'b1);
    ch_req = '0;
  endtask

  initial begin
    rst      = 1'b1;
    idle     = 1'b1;
    ch_req   = '0;
    ch_urg   = '0;
    rd_valid = 1'b0;
    rd_data  = '0;
    rd_fin   = 1'b0;
    err_clr  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      lens[i]  = '0;
      addrs[i] = AW'(16'h0100 * i);
    end

    test_reset();
    test_single();
    test_idle_gate();
    test_round_robin();
    test_urgent();
    test_len_error();
    test_len_edges();
    test_timeout();
    test_reset_mid_data();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
